// File: rtl/fu_branch_resolve.sv
// Branch resolution unit: operand register (S1) feeding a result register (S2)
// that drives the BTB update port and the fetch redirect.
module fu_branch_resolve #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [2:0]        in_funct3,
  input  logic              in_jal,
  input  logic              in_jalr,
  input  logic [WORD_W-1:0] in_rs1,
  input  logic [WORD_W-1:0] in_rs2,
  input  logic [WORD_W-1:0] in_imm,
  input  logic              in_pred_taken,
  input  logic [WORD_W-1:0] in_pred_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              update_btb,
  output logic              branch_outcome,
  output logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] pc,
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] link_data
);

  logic              s1_valid_q;
  logic [WORD_W-1:0] s1_pc_q, s1_rs1_q, s1_rs2_q, s1_imm_q, s1_pred_target_q;
  logic [2:0]        s1_funct3_q;
  logic              s1_jal_q, s1_jalr_q, s1_pred_taken_q;

  logic              s2_valid_q;
  logic              s2_taken_q, s2_misp_q;
  logic [WORD_W-1:0] s2_target_q, s2_pc_q, s2_redirect_q, s2_link_q;

  logic              s2_load, accept;
  logic              taken_d, misp_d;
  logic [WORD_W-1:0] target_d, link_d, redirect_d, jalr_sum;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    jalr_sum = s1_rs1_q + s1_imm_q;
    target_d = s1_jalr_q ? {jalr_sum[WORD_W-1:1], 1'b0} : (s1_pc_q + s1_imm_q);
    link_d   = s1_pc_q + WORD_W'(4);
    taken_d  = 1'b0;
    if (s1_jal_q || s1_jalr_q) begin
      taken_d = 1'b1;
    end else begin
      case (s1_funct3_q)
        3'b000:  taken_d = (s1_rs1_q == s1_rs2_q);
        3'b001:  taken_d = (s1_rs1_q != s1_rs2_q);
        3'b100:  taken_d = ($signed(s1_rs1_q) <  $signed(s1_rs2_q));
        3'b101:  taken_d = ($signed(s1_rs1_q) >= $signed(s1_rs2_q));
        3'b110:  taken_d = (s1_rs1_q <  s1_rs2_q);
        3'b111:  taken_d = (s1_rs1_q >= s1_rs2_q);
        default: taken_d = 1'b0;
      endcase
    end
    misp_d     = (taken_d != s1_pred_taken_q) || (taken_d && (target_d != s1_pred_target_q));
    redirect_d = taken_d ? target_d : link_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q       <= 1'b0;
      s1_pc_q          <= '0;
      s1_rs1_q         <= '0;
      s1_rs2_q         <= '0;
      s1_imm_q         <= '0;
      s1_pred_target_q <= '0;
      s1_funct3_q      <= '0;
      s1_jal_q         <= 1'b0;
      s1_jalr_q        <= 1'b0;
      s1_pred_taken_q  <= 1'b0;
      s2_valid_q       <= 1'b0;
      s2_taken_q       <= 1'b0;
      s2_misp_q        <= 1'b0;
      s2_target_q      <= '0;
      s2_pc_q          <= '0;
      s2_redirect_q    <= '0;
      s2_link_q        <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits matter once killed.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_taken_q    <= taken_d;
          s2_misp_q     <= misp_d;
          s2_target_q   <= target_d;
          s2_pc_q       <= s1_pc_q;
          s2_redirect_q <= redirect_d;
          s2_link_q     <= link_d;
        end
      end
      if (accept) begin
        s1_valid_q       <= 1'b1;
        s1_pc_q          <= in_pc;
        s1_rs1_q         <= in_rs1;
        s1_rs2_q         <= in_rs2;
        s1_imm_q         <= in_imm;
        s1_pred_target_q <= in_pred_target;
        s1_funct3_q      <= in_funct3;
        s1_jal_q         <= in_jal;
        s1_jalr_q        <= in_jalr;
        s1_pred_taken_q  <= in_pred_taken;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign update_btb     = s2_valid_q && out_ready && !flush;
  assign branch_outcome = s2_taken_q;
  assign branch_target  = s2_target_q;
  assign pc             = s2_pc_q;
  assign mispredict     = s2_misp_q;
  assign redirect_pc    = s2_redirect_q;
  assign link_data      = s2_link_q;

endmodule

// File: tb/tb_fu_branch_resolve.sv
// Directed bench for fu_branch_resolve: hand-computed results, handshake,
// backpressure, flush and asynchronous reset scenarios.
module tb_fu_branch_resolve;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_target;
  logic [2:0]  in_funct3;
  logic        in_jal, in_jalr, in_pred_taken;
  logic        flush, out_valid, out_ready, update_btb, branch_outcome, mispredict;
  logic [31:0] branch_target, pc, redirect_pc, link_data;

  int total = 0;
  int bad   = 0;

  fu_branch_resolve #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_funct3(in_funct3),
    .in_jal(in_jal), .in_jalr(in_jalr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .update_btb(update_btb),
    .branch_outcome(branch_outcome), .branch_target(branch_target), .pc(pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .link_data(link_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [2:0] f3,
                       input logic j, input logic jr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic pt, input logic [31:0] ptg);
    in_valid = v; in_pc = p; in_funct3 = f3; in_jal = j; in_jalr = jr;
    in_rs1 = a; in_rs2 = b; in_imm = im; in_pred_taken = pt; in_pred_target = ptg;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic res(input string tag, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] p, input logic mp, input logic [31:0] rd,
                     input logic [31:0] lk);
    chk({tag, ".valid"},    {31'b0, out_valid},      32'd1);
    chk({tag, ".taken"},    {31'b0, branch_outcome}, {31'b0, tk});
    chk({tag, ".target"},   branch_target,           tgt);
    chk({tag, ".pc"},       pc,                      p);
    chk({tag, ".misp"},     {31'b0, mispredict},     {31'b0, mp});
    chk({tag, ".redirect"}, redirect_pc,             rd);
    chk({tag, ".link"},     link_data,               lk);
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.update",    {31'b0, update_btb}, 32'd0);
    chk("rst.target",    branch_target, 32'd0);
    chk("rst.redirect",  redirect_pc, 32'd0);
    nRST = 1'b1;
    tick();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Mispredicted BEQ, two-cycle latency, single update pulse
    drive(1, 32'h100, 3'b000, 0, 0, 5, 5, 32'h20, 0, 0);
    tick(); idle();
    chk("beq.lat1", {31'b0, out_valid}, 32'd0);
    tick();
    res("beq", 1, 32'h120, 32'h100, 1, 32'h120, 32'h104);
    chk("beq.upd", {31'b0, update_btb}, 32'd1);
    tick();
    chk("beq.upd_off", {31'b0, update_btb}, 32'd0);
    chk("beq.drain",   {31'b0, out_valid},  32'd0);

    // Signed vs unsigned, back to back
    drive(1, 32'h300, 3'b100, 0, 0, 32'hFFFF_FFFF, 1, 32'h40, 1, 32'h340); tick();
    drive(1, 32'h310, 3'b110, 0, 0, 32'hFFFF_FFFF, 1, 32'h40, 1, 32'h350); tick();
    res("blt", 1, 32'h340, 32'h300, 0, 32'h340, 32'h304);
    drive(1, 32'h320, 3'b101, 0, 0, 32'h8000_0000, 1, 32'h10, 0, 0); tick();
    res("bltu", 0, 32'h350, 32'h310, 1, 32'h314, 32'h314);
    drive(1, 32'h330, 3'b111, 0, 0, 32'h8000_0000, 1, 32'h10, 1, 32'h340); tick();
    res("bge", 0, 32'h330, 32'h320, 0, 32'h324, 32'h324);
    drive(1, 32'h340, 3'b001, 0, 0, 3, 3, 32'h8, 0, 0); tick();
    res("bgeu", 1, 32'h340, 32'h330, 0, 32'h340, 32'h334);
    drive(1, 32'h350, 3'b010, 0, 0, 7, 7, 32'h8, 1, 32'h358); tick();
    res("bne", 0, 32'h348, 32'h340, 0, 32'h344, 32'h344);
    drive(1, 32'h200, 3'b000, 0, 1, 32'h1001, 9, 32'h2, 1, 32'h1002); tick();
    res("rsvd", 0, 32'h358, 32'h350, 1, 32'h354, 32'h354);
    drive(1, 32'hFFFF_FFF0, 3'b001, 1, 0, 0, 0, 32'h20, 1, 32'h0); tick(); idle();
    res("jalr", 1, 32'h1002, 32'h200, 0, 32'h1002, 32'h204);
    tick();
    // JAL wraps modulo 2^32; predicted target wrong
    res("jal", 1, 32'h10, 32'hFFFF_FFF0, 1, 32'h10, 32'hFFFF_FFF4);
    tick();

    // Backpressure: third instruction stalls until out_ready rises
    out_ready = 1'b0;
    drive(1, 32'h400, 3'b000, 0, 0, 0, 0, 32'h8, 1, 32'h408); tick();
    drive(1, 32'h410, 3'b000, 0, 0, 0, 1, 32'h8, 0, 0); tick();
    drive(1, 32'h420, 3'b001, 0, 0, 0, 1, 32'h8, 1, 32'h428);
    chk("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp.upd_low", {31'b0, update_btb}, 32'd0);
    tick();
    res("bp.hold", 1, 32'h408, 32'h400, 0, 32'h408, 32'h404);
    chk("bp.upd_hold", {31'b0, update_btb}, 32'd0);
    out_ready = 1'b1; #1;
    chk("bp.upd_go", {31'b0, update_btb}, 32'd1);
    chk("bp.in_ready_go", {31'b0, in_ready}, 32'd1);
    tick(); idle();
    res("bp.second", 0, 32'h418, 32'h410, 0, 32'h414, 32'h414);
    tick();
    res("bp.third", 1, 32'h428, 32'h420, 0, 32'h428, 32'h424);
    tick();
    chk("bp.empty", {31'b0, out_valid}, 32'd0);

    // Flush with both stages full and a new instruction presented
    out_ready = 1'b0;
    drive(1, 32'h500, 3'b000, 0, 0, 0, 0, 32'h8, 0, 0); tick();
    drive(1, 32'h510, 3'b000, 0, 0, 0, 0, 32'h8, 0, 0); tick();
    out_ready = 1'b1; flush = 1'b1;
    drive(1, 32'h520, 3'b000, 0, 0, 0, 0, 32'h8, 0, 0); #1;
    chk("fl.upd_forced", {31'b0, update_btb}, 32'd0);
    tick(); flush = 1'b0; idle();
    chk("fl.out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl.in_ready",  {31'b0, in_ready},  32'd1);
    tick();
    chk("fl.nothing", {31'b0, out_valid}, 32'd0);
    tick();
    chk("fl.nothing2", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset with S2 full
    out_ready = 1'b0;
    drive(1, 32'h600, 3'b000, 0, 0, 1, 1, 32'h40, 0, 0); tick(); idle(); tick();
    chk("ar.pre", {31'b0, out_valid}, 32'd1);
    #2 nRST = 1'b0; #1;
    chk("ar.valid",  {31'b0, out_valid}, 32'd0);
    chk("ar.taken",  {31'b0, branch_outcome}, 32'd0);
    chk("ar.misp",   {31'b0, mispredict}, 32'd0);
    chk("ar.pc",     pc, 32'd0);
    chk("ar.target", branch_target, 32'd0);
    chk("ar.link",   link_data, 32'd0);
    #3 nRST = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar.in_ready", {31'b0, in_ready}, 32'd1);
    drive(1, 32'h700, 3'b001, 0, 0, 1, 2, 32'h10, 1, 32'h710); tick(); idle(); tick();
    res("ar.after", 1, 32'h710, 32'h700, 0, 32'h710, 32'h704);
    chk("ar.upd", {31'b0, update_btb}, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_branch_resolve.md
# fu_branch_resolve

Branch resolution functional unit: it sits directly upstream of the branch target buffer. It accepts one issued control-transfer instruction per cycle, computes the real direction and target, and compares them against the fetch-time prediction. It then hands one result per instruction to the BTB update port (`branch_outcome`, `update_btb`, `branch_target`, `pc`) and raises a redirect to fetch on misprediction. It is a two-stage pipeline with valid/ready handshakes on both sides and a synchronous flush.

## Interface
Parameters:
- `WORD_W`, 32, data/address width (matches `word_t`).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  issue presents an instruction.
- `in_ready`  out  1  unit can accept this cycle.
- `in_pc`  in  WORD_W  instruction PC.
- `in_funct3`  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `in_jal`, `in_jalr`  in  1 each  unconditional jump kinds (override `in_funct3`).
- `in_rs1`, `in_rs2`, `in_imm`  in  WORD_W each  operands and sign-extended immediate.
- `in_pred_taken`  in  1  fetch-time predicted direction.
- `in_pred_target`  in  WORD_W  fetch-time predicted target.
- `flush`  in  1  kill all in-flight instructions.
- `out_valid`  out  1  resolved result available.
- `out_ready`  in  1  downstream (BTB/fetch) accepts the result.
- `update_btb`  out  1  BTB write strobe.
- `branch_outcome`  out  1  resolved taken.
- `branch_target`  out  WORD_W  resolved taken-target.
- `pc`  out  WORD_W  PC of the resolved instruction.
- `mispredict`  out  1  prediction was wrong.
- `redirect_pc`  out  WORD_W  correct next PC.
- `link_data`  out  WORD_W  `pc+4` for rd writeback of JAL/JALR.

## Operation
Stage S1 (operand register):
- Captures the inputs on an edge where `in_valid && in_ready`.

Stage S2 (result register), computed from S1 contents:
- Target for branches and JAL: `pc + imm`. Target for JALR: `(rs1 + imm) & ~1`. All sums are modulo 2^WORD_W; carry is discarded.
- Taken: JAL/JALR always. BEQ/BNE use equality. BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare.
- Reserved funct3 (010, 011) with no jump flag: not taken, `mispredict` computed normally.
- `mispredict = (taken != pred_taken) || (taken && target != pred_target)`.
- `redirect_pc = taken ? target : pc+4`. `link_data = pc+4`.
- `branch_target` is the computed target even when not taken.

Handshake and flow control:
- S2 loads whenever it is empty or its result is handed off (`out_valid && out_ready`).
- S1 advances into S2 under the same condition.
- `in_ready = !s1_valid || s2_will_load`, where `s2_will_load` is the condition above.
- `out_valid = s2_valid`.
- `update_btb = out_valid && out_ready`: exactly one pulse per instruction, on its handoff cycle.
- While `out_valid && !out_ready`, every output holds stable and `update_btb` stays 0.

Flush:
- On an edge with `flush=1`, both valid bits clear and any input presented that cycle is discarded.
- Flush has priority over accept and advance. `update_btb` is forced to 0 during the flush cycle.
- The unit never flushes itself; the consumer of `mispredict` drives `flush`.

Reset (`nRST=0`, asynchronous):
- S1/S2 valid bits cleared and all data registers zeroed.
- Therefore `out_valid`, `update_btb`, `branch_outcome`, `mispredict` = 0, and `branch_target`, `pc`, `redirect_pc`, `link_data` = 0.
- `in_ready` = 1 once reset deasserts. Reset mid-flight drops all instructions.

## Timing
- Latency: accepted at edge N → `out_valid` high in the cycle after edge N+1 (2 cycles).
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- Backpressure: with `out_ready` low and S2 full, S1 still accepts one instruction. `in_ready` then drops the next cycle.
- Simultaneous handoff and accept: S2 ← S1 and S1 ← input on the same edge, with no bubble.
- All outputs come directly from registers or simple AND gates of registers. There is no combinational path from `in_*` to `out_*`.

## Test plan
- Mispredicted BEQ: `rs1=rs2=5`, `pc=0x100`, `imm=0x20`, `pred_taken=0` → 2 cycles later `out_valid=1`, `branch_outcome=1`, `branch_target=0x120`, `mispredict=1`, `redirect_pc=0x120`, one-cycle `update_btb`.
- Signed vs unsigned compare: `rs1=0xFFFFFFFF`, `rs2=1`. BLT → taken; BLTU → not taken, `redirect_pc=pc+4`.
- JALR alignment: `rs1=0x1001`, `imm=2`, `pred_target=0x1002`, `pred_taken=1`, `pc=0x200` → target `0x1002`, `mispredict=0`, `link_data=0x204`.
- Backpressure: issue 3 back-to-back with `out_ready=0` → `in_ready` drops after 2 are held. Outputs stay stable with `update_btb=0`. Raising `out_ready` → results in order, one per cycle.
- Flush mid-flight: two instructions in S1/S2, then `flush=1` together with a new `in_valid` → next cycle `out_valid=0`, nothing emitted, `in_ready=1`.
- Reset mid-flight: drop `nRST` asynchronously with S2 full → outputs 0 immediately. After release, a new instruction resolves normally.
